alu_issue_ctrl: RTL

//  Sequencer between the wasm decoder, the operand stack and the combinational ALU.
//  - Accepts one i32 numeric/compare/select opcode, pops 1-3 operands from the stack,

---
 rtl/alu_issue_ctrl_pkg.sv | 62 ++++++
 rtl/alu_issue_ctrl_op_decode.sv | 45 ++++
 rtl/alu_issue_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the ALU issue sequencer: wasm opcodes, ALU control
// codes and the sequencer state encoding.
package alu_issue_ctrl_pkg;

   localparam int ST_WIDTH_DEF = 32;

   // wasm i32 opcode bytes handled by the sequencer
   localparam logic [7:0] OP_SELECT = 8'h1B;
   localparam logic [7:0] OP_EQZ    = 8'h45;
   localparam logic [7:0] OP_EQ     = 8'h46;
   localparam logic [7:0] OP_NE     = 8'h47;
   localparam logic [7:0] OP_LT_S   = 8'h48;
   localparam logic [7:0] OP_LT_U   = 8'h49;
   localparam logic [7:0] OP_GT_S   = 8'h4A;
   localparam logic [7:0] OP_GT_U   = 8'h4B;
   localparam logic [7:0] OP_LE_S   = 8'h4C;
   localparam logic [7:0] OP_LE_U   = 8'h4D;
   localparam logic [7:0] OP_GE_S   = 8'h4E;
   localparam logic [7:0] OP_GE_U   = 8'h4F;
   localparam logic [7:0] OP_ADD    = 8'h6A;
   localparam logic [7:0] OP_SUB    = 8'h6B;
   localparam logic [7:0] OP_AND    = 8'h71;
   localparam logic [7:0] OP_OR     = 8'h72;
   localparam logic [7:0] OP_SHL    = 8'h74;
   localparam logic [7:0] OP_SHR_S  = 8'h75;
   localparam logic [7:0] OP_SHR_U  = 8'h76;
   localparam logic [7:0] OP_ROTL   = 8'h77;
   localparam logic [7:0] OP_ROTR   = 8'h78;

   // 5-bit ALU control codes
   localparam logic [4:0] ALU_ADD    = 5'b00000;
   localparam logic [4:0] ALU_SUB    = 5'b00001;
   localparam logic [4:0] ALU_AND    = 5'b00010;
   localparam logic [4:0] ALU_OR     = 5'b00011;
   localparam logic [4:0] ALU_SELECT = 5'b00100;
   localparam logic [4:0] ALU_EQZ    = 5'b00101;
   localparam logic [4:0] ALU_EQ     = 5'b00110;
   localparam logic [4:0] ALU_LT_U   = 5'b00111;
   localparam logic [4:0] ALU_GT_U   = 5'b01000;
   localparam logic [4:0] ALU_LE_U   = 5'b01001;
   localparam logic [4:0] ALU_GE_U   = 5'b01010;
   localparam logic [4:0] ALU_LT_S   = 5'b01011;
   localparam logic [4:0] ALU_GT_S   = 5'b01100;
   localparam logic [4:0] ALU_LE_S   = 5'b01101;
   localparam logic [4:0] ALU_GE_S   = 5'b01110;
   localparam logic [4:0] ALU_NE     = 5'b01111;
   localparam logic [4:0] ALU_SHL    = 5'b10000;
   localparam logic [4:0] ALU_SHR_S  = 5'b10001;
   localparam logic [4:0] ALU_SHR_U  = 5'b10010;
   localparam logic [4:0] ALU_ROTL   = 5'b10011;
   localparam logic [4:0] ALU_ROTR   = 5'b10100;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_POP  = 3'd1,
      ST_EXEC = 3'd2,
      ST_PUSH = 3'd3,
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } state_e;

endpackage

// File: rtl/alu_issue_ctrl_op_decode.sv
// Combinational opcode decoder: opcode byte -> legality, ALU control, operand count.
module alu_op_decode
   import alu_issue_ctrl_pkg::*;
(
   input  logic [7:0] op_code,
   output logic       legal,
   output logic [4:0] alu_ctrl,
   output logic [1:0] nops
);

   // Table lookup; anything not listed is illegal with zero ctrl/nops
   always_comb begin
      legal    = 1'b1;
      alu_ctrl = 5'b00000;
      nops     = 2'd2;
      unique case (op_code)
         OP_ADD:    alu_ctrl = ALU_ADD;
         OP_SUB:    alu_ctrl = ALU_SUB;
         OP_AND:    alu_ctrl = ALU_AND;
         OP_OR:     alu_ctrl = ALU_OR;
         OP_SELECT: begin alu_ctrl = ALU_SELECT; nops = 2'd3; end
         OP_EQZ:    begin alu_ctrl = ALU_EQZ;    nops = 2'd1; end
         OP_EQ:     alu_ctrl = ALU_EQ;
         OP_NE:     alu_ctrl = ALU_NE;
         OP_LT_S:   alu_ctrl = ALU_LT_S;
         OP_LT_U:   alu_ctrl = ALU_LT_U;
         OP_GT_S:   alu_ctrl = ALU_GT_S;
         OP_GT_U:   alu_ctrl = ALU_GT_U;
         OP_LE_S:   alu_ctrl = ALU_LE_S;
         OP_LE_U:   alu_ctrl = ALU_LE_U;
         OP_GE_S:   alu_ctrl = ALU_GE_S;
         OP_GE_U:   alu_ctrl = ALU_GE_U;
         OP_SHL:    alu_ctrl = ALU_SHL;
         OP_SHR_S:  alu_ctrl = ALU_SHR_S;
         OP_SHR_U:  alu_ctrl = ALU_SHR_U;
         OP_ROTL:   alu_ctrl = ALU_ROTL;
         OP_ROTR:   alu_ctrl = ALU_ROTR;
         default: begin
            legal = 1'b0;
            nops  = 2'd0;
         end
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer: accepts one opcode, pops its operands, drives the ALU for
// one cycle and pushes the result back onto the operand stack.
// Handshakes: an op is taken on op_valid & op_ready; pop_req/push_req are
// levels held (with push_data) until the matching ack is sampled high on a
// rising edge, and the transfer completes on that edge.
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(
   parameter int ST_WIDTH = ST_WIDTH_DEF,
   parameter int DEPTH_W  = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                op_valid,
   output logic                op_ready,
   input  logic [7:0]          op_code,
   input  logic [DEPTH_W-1:0]  stack_depth,
   output logic                pop_req,
   input  logic                pop_ack,
   input  logic [ST_WIDTH-1:0] pop_data,
   output logic                push_req,
   input  logic                push_ack,
   output logic [ST_WIDTH-1:0] push_data,
   output logic [ST_WIDTH-1:0] alu_a,
   output logic [ST_WIDTH-1:0] alu_b,
   output logic [ST_WIDTH-1:0] alu_c,
   output logic [4:0]          alu_ctrl,
   input  logic [31:0]         alu_result,
   output logic                done,
   output logic                err,
   output logic                busy,
   output logic [2:0]          dbg_state
);

   state_e              state_q, state_d;
   logic [4:0]          ctrl_q, ctrl_d;
   logic [1:0]          nops_q, nops_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [ST_WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
   logic [ST_WIDTH-1:0] push_data_q, push_data_d;

   logic                dec_legal;
   logic [4:0]          dec_ctrl;
   logic [1:0]          dec_nops;

   alu_op_decode u_decode (
      .op_code  (op_code),
      .legal    (dec_legal),
      .alu_ctrl (dec_ctrl),
      .nops     (dec_nops)
   );

   // State, operand and result registers; reset drops any op in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ctrl_q      <= '0;
         nops_q      <= '0;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= '0;
         push_data_q <= '0;
      end else begin
         state_q     <= state_d;
         ctrl_q      <= ctrl_d;
         nops_q      <= nops_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         c_q         <= c_d;
         push_data_q <= push_data_d;
      end
   end

   // Next-state and register updates
   always_comb begin
      state_d     = state_q;
      ctrl_d      = ctrl_q;
      nops_d      = nops_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      c_d         = c_q;
      push_data_d = push_data_q;
      unique case (state_q)
         ST_IDLE: begin
            if (op_valid) begin
               ctrl_d = dec_ctrl;
               nops_d = dec_nops;
               cnt_d  = '0;
               // Operands not used by this op must read as zero
               a_d    = '0;
               b_d    = '0;
               c_d    = '0;
               if (!dec_legal || (stack_depth < DEPTH_W'(dec_nops)))
                  state_d = ST_ERR;
               else
                  state_d = ST_POP;
            end
         end
         ST_POP: begin
            if (pop_ack) begin
               unique case (cnt_q)
                  2'd0:    a_d = pop_data;
                  2'd1:    b_d = pop_data;
                  default: c_d = pop_data;
               endcase
               cnt_d = cnt_q + 2'd1;
               if ((cnt_q + 2'd1) == nops_q) state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            push_data_d       = '0;
            push_data_d[31:0] = alu_result;
            state_d           = ST_PUSH;
         end
         ST_PUSH: begin
            if (push_ack) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from the registered state only
   always_comb begin
      op_ready  = (state_q == ST_IDLE);
      busy      = (state_q != ST_IDLE);
      pop_req   = (state_q == ST_POP);
      push_req  = (state_q == ST_PUSH);
      done      = (state_q == ST_DONE);
      err       = (state_q == ST_ERR);
      push_data = push_data_q;
      alu_a     = a_q;
      alu_b     = b_q;
      alu_c     = c_q;
      alu_ctrl  = ctrl_q;
      dbg_state = state_q;
   end

endmodule
